pipe_skid_reg: RTL and testbench

//  Parametrised pipeline stage register: successor to the plain resettable flop, used between
//  CPU pipeline stages (IF/ID, ID/EX, ...). Adds a valid/ready handshake, a 2-entry skid buffer
//  so in_ready is registered (breaks the combinational ready path), synchronous flush for

---
 rtl/pipe_skid_reg_pkg.sv | 24 ++
 rtl/pipe_skid_reg_dff_sr_en.sv | 30 +++
 rtl/pipe_skid_reg.sv | 126 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
// pipe_skid_reg_pkg : shared pipeline-stage constants and occupancy states
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_skid_reg_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Bubble payload used as RESET_VAL by CPU stage instances (addi x0,x0,0).
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg_dff_sr_en.sv
// ============================================================================
// dff_sr_en : synchronous-reset, load-enable payload register
// Rev 1.0
// ============================================================================
`default_nettype none

module dff_sr_en
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// pipe_skid_reg : valid/ready pipeline stage with 2-entry skid buffer,
//                 registered in_ready, synchronous flush and bubble value
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               FLUSH_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  occ_state_e       r_state;
  occ_state_e       w_state_nxt;
  logic             w_accept;
  logic             w_deliver;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_data_clr;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] r_skid;

  // Handshake outputs decode only the state flops, so ready never sees out_ready.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign occ       = r_state;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = in_data;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_en   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_main_en = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_skid_en   = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_deliver) begin
          w_state_nxt = ST_ONE;
          w_main_en   = 1'b1;
          w_main_d    = r_skid;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    // Squash: a beat taken this cycle is swallowed and the payload regs keep still.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
  end

  generate
    if (FLUSH_DATA) begin : g_flush_clr
      assign w_data_clr = rst | flush;
    end else begin : g_flush_keep
      assign w_data_clr = rst;
    end
  endgenerate

  dff_sr_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (w_data_clr),
    .en  (w_main_en),
    .d   (w_main_d),
    .q   (out_data)
  );

  dff_sr_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (w_data_clr),
    .en  (w_skid_en),
    .d   (in_data),
    .q   (r_skid)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// tb_pipe_skid_reg : randomized + directed scoreboard bench, 32-bit flushing
//                    stage and 64-bit payload-keeping stage on shared stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  localparam logic [31:0] RV_A = NOP_BUBBLE;
  localparam logic [63:0] RV_B = 64'hFFFF_0000_0000_0001;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [1:0]  b_occ;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV_A), .FLUSH_DATA(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .occ(a_occ)
  );

  pipe_skid_reg #(.WIDTH(64), .RESET_VAL(RV_B), .FLUSH_DATA(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .occ(b_occ)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];        // beats currently owed by the stage, oldest first
  bit          pend_accept = 1'b0;
  bit          bubble_a = 1'b1;  // A shows RESET_VAL while empty since last rst/flush
  bit          bubble_b = 1'b1;  // B shows RESET_VAL while empty since last rst
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances at the edge.
  task automatic cycle(input bit v, input logic [63:0] d, input bit r, input bit f, input bit rs);
    @(negedge clk);
    #1;
    rst = rs; in_valid = v; in_data = d; out_ready = r; flush = f;
    pend_accept = !rs && v && (sb.size() != 2);
    @(posedge clk);
    if (rs) begin
      sb.delete();
      bubble_a = 1'b1;
      bubble_b = 1'b1;
    end else if (f) begin
      sb.delete();
      bubble_a = 1'b1;
    end else if (pend_accept) begin
      sb.push_back(d);
      bubble_a = 1'b0;
      bubble_b = 1'b0;
    end
  endtask

  // Monitor: compares presented outputs and retires delivered beats.
  initial begin
    int exp_occ;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        exp_occ = sb.size();
        check("a_occ", {62'd0, a_occ}, exp_occ);
        check("b_occ", {62'd0, b_occ}, exp_occ);
        check("a_in_ready", {63'd0, a_in_ready}, {63'd0, exp_occ != 2});
        check("b_in_ready", {63'd0, b_in_ready}, {63'd0, exp_occ != 2});
        check("a_out_valid", {63'd0, a_out_valid}, {63'd0, exp_occ != 0});
        check("b_out_valid", {63'd0, b_out_valid}, {63'd0, exp_occ != 0});
        if (exp_occ != 0) begin
          check("a_out_data", {32'd0, a_out_data}, {32'd0, sb[0][31:0]});
          check("b_out_data", b_out_data, sb[0]);
        end else begin
          if (bubble_a) check("a_bubble", {32'd0, a_out_data}, {32'd0, RV_A});
          if (bubble_b) check("b_bubble", b_out_data, RV_B);
        end
        if (a_out_valid && out_ready && !rst) begin
          if (sb.size() == 0) check("spurious_deliver", 64'd1, 64'd0);
          else void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] held;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset with upstream pushing: nothing may be taken.
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Streaming 1..8 at full throughput.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Stall then skid drain: A, B held, C refused then taken.
    cycle(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a new beat offered.
    cycle(1'b1, 64'h51, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h52, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hBAD0_BAD0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush and reset together, then reset during a full stall.
    cycle(1'b1, 64'h61, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h62, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 64'h71, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h72, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h73, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Payload-keeping stage leaves the squashed beat visible.
    held = 64'h0123_4567_89AB_CDEF;
    cycle(1'b1, held, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("b_keep_data", b_out_data, held);
    check("b_keep_valid", {63'd0, b_out_valid}, 64'd0);
    check("a_flush_data", {32'd0, a_out_data}, {32'd0, RV_A});

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 700) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
